// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a multiplexed active-low anode/cathode display
// bus, waits for each digit to settle, decodes the segment pattern back to
// hex and publishes a complete multi-digit frame with blank/error flags.
module seg_scan_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIGITS-1:0]   anode,
  input  logic [6:0]          cathode,
  output logic [4*DIGITS-1:0] value,
  output logic [DIGITS-1:0]   blank,
  output logic [DIGITS-1:0]   digit_err,
  output logic                frame_valid
);

  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = DIGITS + 7;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Result layout: {blank, err, nibble}. Blank and unknown patterns give
  // nibble 0 so the frame value stays deterministic.
  function automatic logic [5:0] decode_seg(input logic [6:0] pat);
    logic [5:0] r;
    r = 6'h10;
    case (pat)
      7'b0000001: r = 6'h00;
      7'b1001111: r = 6'h01;
      7'b0010010: r = 6'h02;
      7'b0000110: r = 6'h03;
      7'b1001100: r = 6'h04;
      7'b0100100: r = 6'h05;
      7'b0100000: r = 6'h06;
      7'b0001111: r = 6'h07;
      7'b0000000: r = 6'h08;
      7'b0000100: r = 6'h09;
      7'b0001000: r = 6'h0A;
      7'b1100000: r = 6'h0B;
      7'b0110001: r = 6'h0C;
      7'b1000010: r = 6'h0D;
      7'b0110000: r = 6'h0E;
      7'b0111000: r = 6'h0F;
      7'b1111111: r = 6'h20;
      default:    r = 6'h10;
    endcase
    return r;
  endfunction

  logic [DIGITS-1:0]   anode_m, anode_s;
  logic [6:0]          cathode_m, cathode_s;
  logic [BW-1:0]       bus_prev;
  logic                bus_same;
  logic                one_low;
  logic [SW-1:0]       slot;
  logic [5:0]          dec;
  logic [7:0]          cnt;
  state_t              state;
  logic [4*DIGITS-1:0] stage_val;
  logic [DIGITS-1:0]   stage_blank;
  logic [DIGITS-1:0]   stage_err;
  logic [DIGITS-1:0]   captured;

  assign bus_same = ({anode_s, cathode_s} == bus_prev);
  assign one_low  = $onehot(~anode_s);
  assign dec      = decode_seg(cathode_s);

  // Two-flop synchronizer plus a one-cycle-old copy for change detection;
  // idle bus (all ones) is the reset value so reset release looks quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      anode_m   <= '1;
      anode_s   <= '1;
      cathode_m <= '1;
      cathode_s <= '1;
      bus_prev  <= '1;
    end else begin
      anode_m   <= anode;
      anode_s   <= anode_m;
      cathode_m <= cathode;
      cathode_s <= cathode_m;
      bus_prev  <= {anode_s, cathode_s};
    end
  end

  // Stability counter: counts identical consecutive samples, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!bus_same) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Index of the single low anode bit; only meaningful when one_low is set.
  always_comb begin
    slot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!anode_s[i]) slot = SW'(i);
    end
  end

  // Scan FSM with staging, frame publication and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      stage_val   <= '0;
      stage_blank <= '0;
      stage_err   <= '0;
      captured    <= '0;
      value       <= '0;
      blank       <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (&captured) begin
        value       <= stage_val;
        blank       <= stage_blank;
        digit_err   <= stage_err;
        frame_valid <= 1'b1;
        captured    <= '0;
      end
      case (state)
        IDLE: begin
          if (one_low) state <= SETTLE;
        end
        SETTLE: begin
          if (!one_low) begin
            state <= IDLE;
          end else if (bus_same && (cnt == CNT_MAX)) begin
            stage_val[{slot, 2'b00} +: 4] <= dec[3:0];
            stage_blank[slot]             <= dec[5];
            stage_err[slot]               <= dec[4];
            captured[slot]                <= 1'b1;
            state                         <= HOLD;
          end
        end
        HOLD: begin
          // One capture per scan slot: wait for the bus to move on.
          if (!bus_same) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed scans of a 4-digit multiplexed display bus
// checked every cycle against an event-level model of the capture rules.
module tb_seg_scan_capture;

  localparam int DIGITS = 4;
  localparam int S      = 4;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  localparam logic [6:0] P1  = 7'b1001111;
  localparam logic [6:0] P2  = 7'b0010010;
  localparam logic [6:0] P4  = 7'b1001100;
  localparam logic [6:0] P5  = 7'b0100100;
  localparam logic [6:0] P6  = 7'b0100000;
  localparam logic [6:0] P7  = 7'b0001111;
  localparam logic [6:0] P8  = 7'b0000000;
  localparam logic [6:0] PA  = 7'b0001000;
  localparam logic [6:0] PB  = 7'b1100000;
  localparam logic [6:0] BL  = 7'b1111111;
  localparam logic [6:0] BAD = 7'b1010101;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  anode = 4'b1111;
  logic [6:0]  cathode = 7'b1111111;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [3:0]  digit_err;
  logic        frame_valid;

  always #5 clk = ~clk;

  seg_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .anode      (anode),
    .cathode    (cathode),
    .value      (value),
    .blank      (blank),
    .digit_err  (digit_err),
    .frame_valid(frame_valid)
  );

  int   cyc = 0;
  logic rst_seen = 1'b1;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;
  int dut_frames = 0;

  typedef struct {
    int         at_edge;
    int         slot;
    logic [6:0] pat;
  } cap_ev_t;

  cap_ev_t     cap_q[$];
  logic [23:0] exp_q[$];   // {blank, digit_err, value} per completed frame

  logic [15:0] m_stage_val = '0;
  logic [3:0]  m_stage_blank = '0;
  logic [3:0]  m_stage_err = '0;
  logic [3:0]  m_capt = '0;
  int          frame_at = -1;
  logic [15:0] exp_value = '0;
  logic [3:0]  exp_blank = '0;
  logic [3:0]  exp_err = '0;
  logic        exp_fv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Returns {blank, err, nibble} from the segment table.
  function automatic logic [5:0] ref_decode(input logic [6:0] p);
    for (int d = 0; d < 16; d++) begin
      if (SEG_TAB[d] == p) return {2'b00, 4'(d)};
    end
    if (p == 7'b1111111) return 6'b10_0000;
    return 6'b01_0000;
  endfunction

  // Model: a digit held steady for at least S+1 samples with a single low
  // anode is captured S+2 edges after it first appears; the frame is
  // published one edge after the last missing digit is captured.
  always @(negedge clk) begin
    cap_ev_t     ev;
    logic [5:0]  d;
    exp_fv = 1'b0;
    if (rst_seen) begin
      m_stage_val   = '0;
      m_stage_blank = '0;
      m_stage_err   = '0;
      m_capt        = '0;
      frame_at      = -1;
      exp_value     = '0;
      exp_blank     = '0;
      exp_err       = '0;
      cap_q.delete();
    end else begin
      if (frame_at == cyc) begin
        exp_value = m_stage_val;
        exp_blank = m_stage_blank;
        exp_err   = m_stage_err;
        exp_fv    = 1'b1;
        m_capt    = '0;
        frame_at  = -1;
        exp_q.push_back({m_stage_blank, m_stage_err, m_stage_val});
      end
      while (cap_q.size() > 0 && cap_q[0].at_edge <= cyc) begin
        ev = cap_q.pop_front();
        if (ev.at_edge == cyc) begin
          d = ref_decode(ev.pat);
          m_stage_val[ev.slot*4 +: 4] = d[3:0];
          m_stage_blank[ev.slot]      = d[5];
          m_stage_err[ev.slot]        = d[4];
          m_capt[ev.slot]             = 1'b1;
          if (&m_capt) frame_at = cyc + 1;
        end
      end
    end
    if (frame_valid === 1'b1) dut_frames++;
    if (cyc > 0)
      check($sformatf("cycle %0d outputs {fv,blank,err,value}", cyc),
            {7'b0, frame_valid, blank, digit_err, value},
            {7'b0, exp_fv, exp_blank, exp_err, exp_value});
  end

  // ---------------- driver tasks ----------------
  // Drive one bus state for len samples and tell the model if it captures.
  task automatic seg(input logic [3:0] an, input logic [6:0] ca, input int len);
    cap_ev_t ev;
    int      lows;
    anode   = an;
    cathode = ca;
    lows = 0;
    ev.slot = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an[i]) begin
        lows++;
        ev.slot = i;
      end
    end
    if (lows == 1 && len >= S + 1) begin
      ev.at_edge = cyc + 3 + S;
      ev.pat     = ca;
      cap_q.push_back(ev);
    end
    repeat (len) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] an_sel(input int i);
    logic [3:0] a;
    a    = 4'b1111;
    a[i] = 1'b0;
    return a;
  endfunction

  task automatic idle(input int len);
    seg(4'b1111, 7'b1111111, len);
  endtask

  task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3, input int len);
    seg(an_sel(0), p0, len);
    seg(an_sel(1), p1, len);
    seg(an_sel(2), p2, len);
    seg(an_sel(3), p3, len);
  endtask

  // Compares a completed frame against hand-computed literals, both as seen
  // from the DUT and as produced by the model.
  task automatic frame_end(input string name, input int n_frames,
                           input logic [15:0] v, input logic [3:0] b, input logic [3:0] e);
    logic [23:0] m;
    check({name, " frame count"}, dut_frames, n_frames);
    check({name, " value"}, {16'b0, value}, {16'b0, v});
    check({name, " blank/err"}, {24'b0, blank, digit_err}, {24'b0, b, e});
    check({name, " model frames"}, exp_q.size(), n_frames);
    if (n_frames > 0 && exp_q.size() > 0) begin
      m = exp_q[exp_q.size() - 1];
      check({name, " model frame"}, {8'b0, m}, {8'b0, b, e, v});
    end
    exp_q.delete();
    dut_frames = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset value", {16'b0, value}, 32'h0);
    check("reset blank", {28'b0, blank}, 32'h0);
    check("reset digit_err", {28'b0, digit_err}, 32'h0);
    check("reset frame_valid", {31'b0, frame_valid}, 32'h0);
    idle(2);
    dut_frames = 0;

    // Digits held only 3 samples never settle.
    scan4(P1, P2, PA, PB, 3);
    idle(8);
    frame_end("short hold", 0, 16'h0000, 4'b0000, 4'b0000);

    // Plain scan.
    scan4(P1, P2, PA, PB, 10);
    idle(5);
    frame_end("scan BA21", 1, 16'hBA21, 4'b0000, 4'b0000);

    // Blank and invalid patterns.
    scan4(P1, BAD, BL, PB, 10);
    idle(5);
    frame_end("blank/err", 1, 16'hB001, 4'b0100, 4'b0010);

    // Multi-hot anode glitch between digits 1 and 2.
    seg(an_sel(0), P1, 10);
    seg(an_sel(1), P2, 10);
    seg(4'b1100, P8, 5);
    seg(an_sel(2), PA, 10);
    seg(an_sel(3), PB, 10);
    idle(5);
    frame_end("glitch", 1, 16'hBA21, 4'b0000, 4'b0000);

    // Reset in the middle of a frame discards the partial capture.
    seg(an_sel(0), P1, 10);
    seg(an_sel(1), P2, 10);
    idle(3);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("mid reset value", {16'b0, value}, 32'h0);
    idle(2);
    scan4(P4, P5, P6, P7, 10);
    idle(5);
    frame_end("after reset", 1, 16'h7654, 4'b0000, 4'b0000);

    // Recapture of digit 0 overwrites its staging slot.
    seg(an_sel(0), P1, 10);
    seg(an_sel(0), P8, 10);
    seg(an_sel(1), P2, 10);
    seg(an_sel(2), PA, 10);
    seg(an_sel(3), PB, 10);
    idle(5);
    frame_end("recapture", 1, 16'hBA28, 4'b0000, 4'b0000);

    idle(3);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
